fb_swap_ctrl: RTL and testbench

Double-buffer controller for the 320x240 framebuffer. It owns the write ports of two framebuffer banks and routes the drawing client's writes to the back bank. It also runs a hardware clear of the back bank and swaps front/back only at the start of vertical sync, so the scan-out side never shows a partially drawn frame. It sits between the drawing logic and the two dual-port RAM banks; `front_sel` drives the scan-out read mux.

---
 rtl/fb_swap_if.sv | 32 +++
 rtl/fb_swap_ctrl.sv | 136 +++++++++++++
 tb/tb_fb_swap_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_swap_if.sv
// Signal bundle between the drawing client, the VGA timing side, the swap
// controller and the two framebuffer bank write ports.
interface fb_swap_if #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned MEM_WIDTH  = 8
);
  logic                  v_sync;
  logic                  swap_req;
  logic                  clear_req;
  logic [MEM_WIDTH-1:0]  clear_color;
  logic                  usr_wen;
  logic [ADDR_WIDTH-1:0] usr_addr;
  logic [MEM_WIDTH-1:0]  usr_din;
  logic                  usr_ready;
  logic                  busy;
  logic                  swap_done;
  logic                  front_sel;
  logic                  bank0_we;
  logic                  bank1_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [MEM_WIDTH-1:0]  wr_din;

  modport master (
    output v_sync, swap_req, clear_req, clear_color, usr_wen, usr_addr, usr_din,
    input  usr_ready, busy, swap_done, front_sel, bank0_we, bank1_we, wr_addr, wr_din
  );

  modport slave (
    input  v_sync, swap_req, clear_req, clear_color, usr_wen, usr_addr, usr_din,
    output usr_ready, busy, swap_done, front_sel, bank0_we, bank1_we, wr_addr, wr_din
  );
endinterface

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller: routes client writes to the back bank, clears the
// back bank in hardware and swaps front/back only at the falling edge of v_sync.
module fb_swap_ctrl #(
  parameter int unsigned RES_X     = 320,
  parameter int unsigned RES_Y     = 240,
  parameter int unsigned MEM_WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  fb_swap_if.slave bus
);
  localparam int unsigned MEM_DEPTH  = RES_X * RES_Y;
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_WAIT_VS = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q,  clr_addr_d;
  logic [MEM_WIDTH-1:0]  clr_color_q, clr_color_d;
  logic                  swap_pend_q, swap_pend_d;
  logic                  front_sel_q, front_sel_d;
  logic                  swap_done_q, swap_done_d;
  logic                  vs_q;
  logic                  bank0_we_q,  bank0_we_d;
  logic                  bank1_we_q,  bank1_we_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
  logic [MEM_WIDTH-1:0]  wr_din_q,    wr_din_d;

  logic vs_fall;
  logic wr_c;
  logic usr_in_range;

  assign vs_fall      = vs_q & ~bus.v_sync;
  assign usr_in_range = 32'(bus.usr_addr) < MEM_DEPTH;

  // Registered state, flags and write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      swap_pend_q <= 1'b0;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      vs_q        <= 1'b1;
      bank0_we_q  <= 1'b0;
      bank1_we_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      swap_pend_q <= swap_pend_d;
      front_sel_q <= front_sel_d;
      swap_done_q <= swap_done_d;
      vs_q        <= bus.v_sync;
      bank0_we_q  <= bank0_we_d;
      bank1_we_q  <= bank1_we_d;
      wr_addr_q   <= wr_addr_d;
      wr_din_q    <= wr_din_d;
    end
  end

  // Next-state and write-port decode
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    swap_pend_d = swap_pend_q;
    front_sel_d = front_sel_q;
    swap_done_d = 1'b0;
    wr_c        = 1'b0;
    wr_addr_d   = '0;
    wr_din_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.usr_wen && usr_in_range) begin
          wr_c      = 1'b1;
          wr_addr_d = bus.usr_addr;
          wr_din_d  = bus.usr_din;
        end
        if (bus.clear_req) begin
          state_d     = ST_CLEAR;
          clr_color_d = bus.clear_color;
          clr_addr_d  = '0;
          if (bus.swap_req) swap_pend_d = 1'b1;
        end else if (bus.swap_req) begin
          state_d = ST_WAIT_VS;
        end
      end

      ST_CLEAR: begin
        wr_c      = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_din_d  = clr_color_q;
        if (bus.swap_req) swap_pend_d = 1'b1;
        if (clr_addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          clr_addr_d = '0;
          state_d    = (swap_pend_q || bus.swap_req) ? ST_WAIT_VS : ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
      end

      ST_WAIT_VS: begin
        if (vs_fall) begin
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
          swap_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Back bank is the one not on screen; the write lands before any swap.
    bank0_we_d = wr_c &  front_sel_q;
    bank1_we_d = wr_c & ~front_sel_q;
  end

  assign bus.usr_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.swap_done = swap_done_q;
  assign bus.front_sel = front_sel_q;
  assign bus.bank0_we  = bank0_we_q;
  assign bus.bank1_we  = bank1_we_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_din    = wr_din_q;
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl on a 4x3 framebuffer (12 words, 4-bit
// address) so an out-of-range client address is representable.
module tb_fb_swap_ctrl;
  localparam int unsigned RES_X = 4;
  localparam int unsigned RES_Y = 3;
  localparam int unsigned DEPTH = RES_X * RES_Y;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DW    = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fb_swap_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(DW)) bus ();

  fb_swap_ctrl #(.RES_X(RES_X), .RES_Y(RES_Y), .MEM_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_no_write(input string tag);
    check({tag, ".b0we"}, 32'(bus.bank0_we), 0);
    check({tag, ".b1we"}, 32'(bus.bank1_we), 0);
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.v_sync       = 1'b1;
    bus.swap_req     = 1'b0;
    bus.clear_req    = 1'b0;
    bus.clear_color  = '0;
    bus.usr_wen      = 1'b0;
    bus.usr_addr     = '0;
    bus.usr_din      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst.front_sel", 32'(bus.front_sel), 0);
    check("rst.busy",      32'(bus.busy), 0);
    check("rst.ready",     32'(bus.usr_ready), 1);
    check("rst.swap_done", 32'(bus.swap_done), 0);
    check_no_write("rst");

    // Client write in IDLE lands in bank1 one cycle later, for one cycle
    @(posedge clk); #1;
    bus.usr_wen  = 1'b1;
    bus.usr_addr = AW'(5);
    bus.usr_din  = 8'h2A;
    step();
    bus.usr_wen = 1'b0;
    check("wr.b1we", 32'(bus.bank1_we), 1);
    check("wr.b0we", 32'(bus.bank0_we), 0);
    check("wr.addr", 32'(bus.wr_addr), 5);
    check("wr.din",  32'(bus.wr_din), 32'h2A);
    step();
    check_no_write("wr.once");

    // Out-of-range address is dropped
    bus.usr_wen  = 1'b1;
    bus.usr_addr = AW'(13);
    bus.usr_din  = 8'h3F;
    step();
    bus.usr_wen = 1'b0;
    check_no_write("oor");

    // Reset in the middle of a clear
    bus.clear_req   = 1'b1;
    bus.clear_color = 8'h15;
    step();
    bus.clear_req = 1'b0;
    repeat (4) step();
    check("mid.addr", 32'(bus.wr_addr), 3);
    check("mid.b1we", 32'(bus.bank1_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.front_sel", 32'(bus.front_sel), 0);
    check("mrst.busy",      32'(bus.busy), 0);
    check("mrst.ready",     32'(bus.usr_ready), 1);
    check_no_write("mrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mrst.idle_busy", 32'(bus.busy), 0);
    check_no_write("mrst.idle");

    // Full clear restarts at address 0; client writes during clear are dropped
    bus.clear_req   = 1'b1;
    bus.clear_color = 8'h30;
    step();
    bus.clear_req = 1'b0;
    check("clr.busy",  32'(bus.busy), 1);
    check("clr.ready", 32'(bus.usr_ready), 0);
    check_no_write("clr.first");
    bus.usr_wen  = 1'b1;
    bus.usr_addr = AW'(9);
    bus.usr_din  = 8'h11;
    for (int i = 0; i < int'(DEPTH); i++) begin
      step();
      check($sformatf("clr%0d.b1we", i), 32'(bus.bank1_we), 1);
      check($sformatf("clr%0d.b0we", i), 32'(bus.bank0_we), 0);
      check($sformatf("clr%0d.addr", i), 32'(bus.wr_addr), 32'(i));
      check($sformatf("clr%0d.din", i),  32'(bus.wr_din), 32'h30);
      check($sformatf("clr%0d.ready", i), 32'(bus.usr_ready), (i == int'(DEPTH) - 1) ? 1 : 0);
    end
    bus.usr_wen = 1'b0;
    step();
    check_no_write("clr.end");
    check("clr.end.busy", 32'(bus.busy), 0);

    // Swap: a write alongside swap_req still lands in bank1, then stall 20 cycles
    bus.swap_req = 1'b1;
    bus.usr_wen  = 1'b1;
    bus.usr_addr = AW'(2);
    bus.usr_din  = 8'h07;
    step();
    bus.swap_req = 1'b0;
    check("sw.last.b1we", 32'(bus.bank1_we), 1);
    check("sw.last.addr", 32'(bus.wr_addr), 2);
    check("sw.ready",     32'(bus.usr_ready), 0);
    check("sw.busy",      32'(bus.busy), 1);
    for (int i = 0; i < 19; i++) begin
      step();
      check($sformatf("sw.wait%0d.ready", i), 32'(bus.usr_ready), 0);
      check($sformatf("sw.wait%0d.b1we", i), 32'(bus.bank1_we), 0);
    end
    check("sw.wait.front", 32'(bus.front_sel), 0);
    bus.v_sync = 1'b0;
    step();
    check("sw.front_sel", 32'(bus.front_sel), 1);
    check("sw.done",      32'(bus.swap_done), 1);
    check("sw.ready_now", 32'(bus.usr_ready), 1);
    check_no_write("sw.edge");
    step();
    bus.usr_wen = 1'b0;
    check("sw.done_pulse", 32'(bus.swap_done), 0);
    check("sw.post.b0we",  32'(bus.bank0_we), 1);
    check("sw.post.b1we",  32'(bus.bank1_we), 0);
    check("sw.post.addr",  32'(bus.wr_addr), 2);
    bus.v_sync = 1'b1;
    repeat (2) step();

    // Clear and swap together; v_sync fall mid-clear is ignored
    bus.clear_req   = 1'b1;
    bus.swap_req    = 1'b1;
    bus.clear_color = 8'h0C;
    step();
    bus.clear_req = 1'b0;
    bus.swap_req  = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == 3) bus.v_sync = 1'b0;
      if (i == 5) bus.v_sync = 1'b1;
      step();
      check($sformatf("cs%0d.b0we", i), 32'(bus.bank0_we), 1);
      check($sformatf("cs%0d.addr", i), 32'(bus.wr_addr), 32'(i));
      check($sformatf("cs%0d.din", i),  32'(bus.wr_din), 32'h0C);
      check($sformatf("cs%0d.front", i), 32'(bus.front_sel), 1);
      check($sformatf("cs%0d.done", i), 32'(bus.swap_done), 0);
    end
    step();
    check("cs.wait.busy",  32'(bus.busy), 1);
    check("cs.wait.ready", 32'(bus.usr_ready), 0);
    check("cs.wait.front", 32'(bus.front_sel), 1);
    check_no_write("cs.wait");
    bus.v_sync = 1'b0;
    step();
    check("cs.front_sel", 32'(bus.front_sel), 0);
    check("cs.done",      32'(bus.swap_done), 1);
    check("cs.busy",      32'(bus.busy), 0);
    bus.v_sync = 1'b1;
    step();
    check("cs.done_pulse", 32'(bus.swap_done), 0);

    // v_sync fall in IDLE with nothing pending
    repeat (2) step();
    bus.v_sync = 1'b0;
    step();
    check("idle_vs.front", 32'(bus.front_sel), 0);
    check("idle_vs.done",  32'(bus.swap_done), 0);
    step();
    check("idle_vs.done2", 32'(bus.swap_done), 0);
    bus.v_sync = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
